tick_updown_counter: RTL and testbench
======================================

Name: tick_updown_counter

Overview:
- Parametrised successor to the board-level 4-bit LED counter. Fully synchronous to the 100 MHz source clock.
- A prescaler generates a one-cycle clock-enable tick instead of a derived clock. On each tick the counter steps up or down.
- Adds runtime direction, wrap/saturate mode, synchronous load, enable, and terminal/wrap status.
- Sits between the board clock/reset and the LED/display outputs. It is the block swapped in and out by the partial-reconfiguration region.

Parameters:
- WIDTH, 4, counter width in bits (1..32).
- DIV_COUNT, 33554432, source-clock cycles per tick (>=1; 1 = tick every cycle).
- DIV_WIDTH, 26, prescaler width; must satisfy 2^DIV_WIDTH >= DIV_COUNT.
- RST_VAL, {WIDTH{1'b1}}, counter value after reset (all ones, down-count default).

Ports:
- clk, input, 1, source clock (100 MHz); sole clock.
- rst, input, 1, asynchronous active-high reset.
- en, input, 1, 1 = prescaler runs and counter may step; 0 = freeze all state.
- dir, input, 1, 1 = count up, 0 = count down.
- sat_mode, input, 1, 1 = saturate at bounds, 0 = wrap around.
- load, input, 1, synchronous load strobe.
- load_val, input, WIDTH, value loaded when load=1.
- counter_out, output, WIDTH, current count (registered).
- tick, output, 1, registered one-cycle pulse; the cycle the counter steps.
- tc, output, 1, terminal count: (dir ? counter_out==MAX : counter_out==0); combinational from registers and dir.
- wrap, output, 1, registered one-cycle pulse when a step wraps (wrap mode) or is blocked at a bound (saturate mode).

Behaviour:
- Clocking:
  - Single clock domain; no logic clocked by any derived signal.
  - rst is asynchronous assert. All flops are on posedge clk or posedge rst.
- Reset values: counter_out=RST_VAL, prescaler=0, tick=0, wrap=0. tc follows the reset state (RST_VAL all ones with dir=0 gives tc=0).
- Priority per clock edge: load > en=0 > normal.
- Load:
  - counter_out<=load_val and prescaler<=0; tick<=0, wrap<=0.
  - Takes effect regardless of en.
  - A load on a cycle that would tick suppresses that tick.
- en=0: prescaler and counter_out hold; tick<=0, wrap<=0.
- Prescaler:
  - When en=1, the prescaler increments each cycle.
  - When prescaler==DIV_COUNT-1 it returns to 0 and the step condition is true for that cycle.
  - Tick period is exactly DIV_COUNT cycles.
  - With DIV_COUNT=1 the prescaler stays 0 and the step condition is true every enabled cycle.
- Step, on the step condition, MAX=2^WIDTH-1:
  - dir=1, counter_out<MAX: +1.
  - dir=0, counter_out>0: -1.
  - At the bound, sat_mode=0: wrap (MAX->0 up, 0->MAX down), wrap<=1.
  - At the bound, sat_mode=1: hold, wrap<=1.
  - tick<=1 on every step cycle, including blocked saturate steps.
- Latency:
  - counter_out, tick and wrap all update on the same edge as the step.
  - The first step after reset or load occurs DIV_COUNT enabled cycles later.
- dir and sat_mode are sampled on the step cycle only. Changing them mid-period does not reset the prescaler.
- tc responds immediately to a dir change.
- A reset asserted mid-period clears the prescaler. There is no partial-period carry-over after release.
- Arithmetic is modulo 2^WIDTH; no signed interpretation.

Test Plan:
- WIDTH=4, DIV_COUNT=4, rst pulse, en=1, dir=0, sat_mode=0 -> counter_out=F after reset; tick every 4th cycle. Sequence F,E,...,0,F, with wrap=1 on the 0->F step; tc=1 while counter_out=0.
- dir=1, sat_mode=1, load load_val=D -> counter_out D,E,F,F,F; wrap=1 on each blocked step; tick still every 4 cycles; tc=1 at F.
- Load of 7 issued one cycle before a pending tick -> that tick is suppressed; counter_out=7; next step exactly 4 cycles after the load.
- en=0 for 10 cycles mid-period at prescaler=2 -> counter_out and prescaler frozen; after en=1 the step occurs 2 cycles later.
- rst asserted asynchronously between edges with counter_out=5 -> counter_out=F immediately, without waiting for an edge; tick=wrap=0; first step DIV_COUNT cycles after release.
- DIV_COUNT=1, WIDTH=2, dir=1, sat_mode=0 -> steps every cycle: 3,0,1,2,3,0 (RST_VAL=3); wrap pulses on each 3->0.

Source files
------------

// File: rtl/tick_updown_counter_if.sv
// Control and status bundle for tick_updown_counter.
//   master : drives en, dir, sat_mode, load, load_val; observes status
//   slave  : the counter itself
//   en, dir, sat_mode, load : run enable, count direction (1=up), saturate
//                             mode (1=saturate, 0=wrap), synchronous load strobe
//   load_val                : value taken on load
//   counter_out, tick       : registered count and one-cycle step pulse
//   tc                      : terminal count, combinational from count and dir
//   wrap                    : registered pulse on a wrapped or blocked step
interface tick_updown_counter_if #(
   parameter int unsigned WIDTH = 4
) ();
   logic             en;
   logic             dir;
   logic             sat_mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] counter_out;
   logic             tick;
   logic             tc;
   logic             wrap;

   modport master (
      output en, dir, sat_mode, load, load_val,
      input  counter_out, tick, tc, wrap
   );

   modport slave (
      input  en, dir, sat_mode, load, load_val,
      output counter_out, tick, tc, wrap
   );
endinterface

// File: rtl/tick_updown_counter.sv
// Prescaled up/down counter with wrap/saturate modes and synchronous load.
// A prescaler produces a one-cycle step condition every DIV_COUNT enabled
// cycles; on that cycle the count moves one step in the direction given by
// dir, wrapping or holding at the bounds according to sat_mode.
//   clk : source clock, sole clock of the block
//   rst : asynchronous active-high reset
//   bus : tick_updown_counter_if slave (controls in, count/status out)
module tick_updown_counter #(
   parameter int unsigned       WIDTH     = 4,
   parameter int unsigned       DIV_COUNT = 33554432,
   parameter int unsigned       DIV_WIDTH = 26,
   parameter logic [WIDTH-1:0]  RST_VAL   = {WIDTH{1'b1}}
) (
   input  logic                 clk,
   input  logic                 rst,
   tick_updown_counter_if.slave bus
);
   localparam logic [WIDTH-1:0]     MAX_VAL = {WIDTH{1'b1}};
   localparam logic [DIV_WIDTH-1:0] LAST_PH = DIV_WIDTH'(DIV_COUNT - 1);

   logic [DIV_WIDTH-1:0] r_presc;
   logic [WIDTH-1:0]     r_count;
   logic                 r_tick;
   logic                 r_wrap;

   logic                 w_step;
   logic                 w_at_bound;
   logic                 w_blocked;
   logic [WIDTH-1:0]     w_count_nxt;

   // Last prescaler phase; with DIV_COUNT=1 the prescaler sits at 0 and this is always true.
   assign w_step      = (r_presc == LAST_PH);
   assign w_at_bound  = bus.dir ? (r_count == MAX_VAL) : (r_count == '0);
   assign w_blocked   = w_at_bound & bus.sat_mode;
   // Modulo arithmetic gives MAX->0 and 0->MAX wrap for free.
   assign w_count_nxt = bus.dir ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));

   // Priority: reset > load > en=0 > normal stepping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= RST_VAL;
         r_presc <= '0;
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
      end else if (bus.load) begin
         r_count <= bus.load_val;
         r_presc <= '0;
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
      end else if (!bus.en) begin
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_presc <= w_step ? '0 : (r_presc + DIV_WIDTH'(1));
         r_tick  <= w_step;
         r_wrap  <= w_step & w_at_bound;
         if (w_step && !w_blocked) begin
            r_count <= w_count_nxt;
         end
      end
   end

   assign bus.counter_out = r_count;
   assign bus.tick        = r_tick;
   assign bus.wrap        = r_wrap;
   assign bus.tc          = w_at_bound;
endmodule

// File: tb/tb_tick_updown_counter.sv
// Scoreboard bench for tick_updown_counter: instance A (WIDTH=4, DIV_COUNT=4)
// and instance B (WIDTH=2, DIV_COUNT=1) share stimulus. The driver updates a
// behavioural model and queues the expected outputs; the monitor pops and
// compares after every clock edge and after every asynchronous reset assertion.
module tb_tick_updown_counter;
   typedef struct packed {
      logic [3:0] cnt;
      logic       tick;
      logic       wrap;
      logic       tc;
   } obs_t;

   typedef struct packed {
      obs_t a;
      obs_t b;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   done = 1'b0;

   exp_t exp_q[$];

   int   m_cnt  [2];
   int   m_ph   [2];
   bit   m_tick [2];
   bit   m_wrap [2];

   int   n_checks = 0;
   int   n_fail   = 0;

   tick_updown_counter_if #(.WIDTH(4)) bus_a ();
   tick_updown_counter_if #(.WIDTH(2)) bus_b ();

   tick_updown_counter #(
      .WIDTH(4), .DIV_COUNT(4), .DIV_WIDTH(2), .RST_VAL(4'hF)
   ) u_dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );

   tick_updown_counter #(
      .WIDTH(2), .DIV_COUNT(1), .DIV_WIDTH(1), .RST_VAL(2'h3)
   ) u_dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

   always #5 clk = ~clk;

   function automatic int max_of(input int k);
      return (k == 0) ? 15 : 3;
   endfunction

   function automatic int div_of(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   function automatic bit tc_of(input int k, input bit d);
      return d ? (m_cnt[k] == max_of(k)) : (m_cnt[k] == 0);
   endfunction

   function automatic exp_t make_exp(input bit d);
      exp_t e;
      e.a.cnt  = 4'(m_cnt[0]);
      e.a.tick = m_tick[0];
      e.a.wrap = m_wrap[0];
      e.a.tc   = tc_of(0, d);
      e.b.cnt  = 4'(m_cnt[1]);
      e.b.tick = m_tick[1];
      e.b.wrap = m_wrap[1];
      e.b.tc   = tc_of(1, d);
      return e;
   endfunction

   // Reference behaviour: count steps once every div_of(k) enabled cycles.
   task automatic model_edge(input bit ld, input bit en, input bit d, input bit sat, input int lv);
      int t;
      for (int k = 0; k < 2; k++) begin
         m_tick[k] = 1'b0;
         m_wrap[k] = 1'b0;
         if (ld) begin
            m_cnt[k] = lv % (max_of(k) + 1);
            m_ph[k]  = 0;
         end else if (en) begin
            m_ph[k] = m_ph[k] + 1;
            if (m_ph[k] == div_of(k)) begin
               m_ph[k]   = 0;
               m_tick[k] = 1'b1;
               t = m_cnt[k] + (d ? 1 : -1);
               if (t < 0 || t > max_of(k)) begin
                  m_wrap[k] = 1'b1;
                  if (!sat) m_cnt[k] = (t + max_of(k) + 1) % (max_of(k) + 1);
               end else begin
                  m_cnt[k] = t;
               end
            end
         end
      end
   endtask

   task automatic drive(input bit en, input bit d, input bit sat, input bit ld, input int lv);
      @(negedge clk);
      rst = 1'b0;
      bus_a.en = en;  bus_a.dir = d;  bus_a.sat_mode = sat;  bus_a.load = ld;
      bus_a.load_val = 4'(lv);
      bus_b.en = en;  bus_b.dir = d;  bus_b.sat_mode = sat;  bus_b.load = ld;
      bus_b.load_val = 2'(lv);
      model_edge(ld, en, d, sat, lv);
      exp_q.push_back(make_exp(d));
   endtask

   // One entry for the instant of assertion, one for the edge while held.
   task automatic async_reset();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k]  = max_of(k);
         m_ph[k]   = 0;
         m_tick[k] = 1'b0;
         m_wrap[k] = 1'b0;
      end
      exp_q.push_back(make_exp(bus_a.dir));
      exp_q.push_back(make_exp(bus_a.dir));
      rst = 1'b1;
   endtask

   task automatic mid_cycle_reset();
      @(negedge clk);
      rst = 1'b0;
      #2;
      async_reset();
   endtask

   // Driver
   initial begin
      bit en, d, sat, ld;
      int lv;
      bus_a.en = 1'b0; bus_a.dir = 1'b0; bus_a.sat_mode = 1'b0; bus_a.load = 1'b0; bus_a.load_val = '0;
      bus_b.en = 1'b0; bus_b.dir = 1'b0; bus_b.sat_mode = 1'b0; bus_b.load = 1'b0; bus_b.load_val = '0;
      #1;
      async_reset();

      // Down-count wrap run: F..0 then F.
      for (int i = 0; i < 70; i++) drive(1, 0, 0, 0, 0);
      // Load D, count up saturating.
      drive(1, 1, 1, 1, 13);
      for (int i = 0; i < 24; i++) drive(1, 1, 1, 0, 0);
      // Load 7 on the cycle that would otherwise step.
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 7);
      for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, 0);
      // Freeze mid-period.
      for (int i = 0; i < 2; i++) drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0);
      // Asynchronous reset with count=5 mid-period.
      drive(1, 0, 0, 1, 5);
      for (int i = 0; i < 2; i++) drive(1, 0, 0, 0, 0);
      mid_cycle_reset();
      for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0);
      // Up-count wrap (instance B: 3,0,1,2,3,0).
      mid_cycle_reset();
      for (int i = 0; i < 12; i++) drive(1, 1, 0, 0, 0);

      // Randomised traffic.
      en = 1'b1; d = 1'b0; sat = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            mid_cycle_reset();
         end else begin
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) d   = ~d;
            if ($urandom_range(0, 9) == 0) sat = ~sat;
            ld  = ($urandom_range(0, 19) == 0);
            lv  = int'($urandom_range(0, 15));
            drive(en, d, sat, ld, lv);
         end
      end
      @(negedge clk);
      done = 1'b1;
   end

   // Monitor
   initial begin
      exp_t e;
      obs_t act_a, act_b;
      int   cyc;
      int   drain;
      cyc   = 0;
      drain = 0;
      forever begin
         @(posedge clk or posedge rst);
         #1;
         cyc++;
         if (exp_q.size() == 0) begin
            if (done) break;
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty at sample %0d: no expected entry queued", cyc);
         end else begin
            e     = exp_q.pop_front();
            act_a = {bus_a.counter_out, bus_a.tick, bus_a.wrap, bus_a.tc};
            act_b = {2'b00, bus_b.counter_out, bus_b.tick, bus_b.wrap, bus_b.tc};
            n_checks++;
            if (act_a !== e.a) begin
               n_fail++;
               $display("FAIL dut_a sample %0d: got cnt=%h tick=%b wrap=%b tc=%b, want cnt=%h tick=%b wrap=%b tc=%b",
                        cyc, act_a.cnt, act_a.tick, act_a.wrap, act_a.tc, e.a.cnt, e.a.tick, e.a.wrap, e.a.tc);
            end
            n_checks++;
            if (act_b !== e.b) begin
               n_fail++;
               $display("FAIL dut_b sample %0d: got cnt=%h tick=%b wrap=%b tc=%b, want cnt=%h tick=%b wrap=%b tc=%b",
                        cyc, act_b.cnt, act_b.tick, act_b.wrap, act_b.tc, e.b.cnt, e.b.tick, e.b.wrap, e.b.tc);
            end
            if (done) begin
               drain++;
               if (drain > 20) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL drain_timeout: %0d entries left, want 0", exp_q.size());
                  break;
               end
            end
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
